// File: rtl/axis_spm_offset_mover_if.sv
// Command/status bundle between the host register block and the SPM offset mover.
// The abort wire exists only when SPM_OFFSET_MOVER_ABORT_EN is defined.
interface axis_spm_offset_mover_if #(
  parameter int PRESCALE_W = 16
);
  logic                  start;
  logic signed [31:0]    x_target;
  logic signed [31:0]    y_target;
  logic signed [31:0]    z_target;
  logic [31:0]           step;
  logic [PRESCALE_W-1:0] rate_div;
`ifdef SPM_OFFSET_MOVER_ABORT_EN
  logic                  abort;
`endif
  logic signed [31:0]    x0;
  logic signed [31:0]    y0;
  logic signed [31:0]    z0;
  logic                  busy;
  logic                  done;

  modport master (
`ifdef SPM_OFFSET_MOVER_ABORT_EN
    output abort,
`endif
    output start, x_target, y_target, z_target, step, rate_div,
    input  x0, y0, z0, busy, done
  );

  modport slave (
`ifdef SPM_OFFSET_MOVER_ABORT_EN
    input  abort,
`endif
    input  start, x_target, y_target, z_target, step, rate_div,
    output x0, y0, z0, busy, done
  );
endinterface

// File: rtl/axis_spm_offset_mover.sv
// Ramps the SPM (x0, y0, z0) offset vector to latched targets at a bounded step per prescaled tick.
// Optional feature macro: SPM_OFFSET_MOVER_ABORT_EN (adds abort to the interface).
module axis_spm_offset_mover #(
  parameter int SETTLE_CYCLES = 16,
  parameter int PRESCALE_W    = 16
) (
  input  logic                   a_clk,
  input  logic                   a_rst,
  axis_spm_offset_mover_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_MOVE   = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

  logic [1:0]            state;
  logic [PRESCALE_W-1:0] presc;
  logic [SETTLE_W-1:0]   settle_cnt;
  logic signed [31:0]    x_cur, y_cur, z_cur;
  logic signed [31:0]    x_tgt, y_tgt, z_tgt;
  logic signed [31:0]    x_nxt, y_nxt, z_nxt;
  logic signed [32:0]    step_eff;
  logic                  tick;
  logic                  done_q;
  logic                  unused_step_msb;

  assign unused_step_msb = bus.step[31];

  // Distance is taken in 33 bits so a full-range move cannot wrap before the compare.
  function automatic logic signed [31:0] next_axis(input logic signed [31:0] cur,
                                                   input logic signed [31:0] tgt,
                                                   input logic signed [32:0] s);
    logic signed [32:0] d;
    d = {tgt[31], tgt} - {cur[31], cur};
    if (d > s)
      next_axis = cur + s[31:0];
    else if (d < -s)
      next_axis = cur - s[31:0];
    else
      next_axis = tgt;
  endfunction

  always_comb begin
    step_eff = {2'b00, bus.step[30:0]};
    if (bus.step[30:0] == 31'd0)
      step_eff = 33'sd1;
    x_nxt = next_axis(x_cur, x_tgt, step_eff);
    y_nxt = next_axis(y_cur, y_tgt, step_eff);
    z_nxt = next_axis(z_cur, z_tgt, step_eff);
  end

  assign tick = (presc == bus.rate_div);

  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      state      <= ST_IDLE;
      presc      <= '0;
      settle_cnt <= '0;
      x_cur      <= '0;
      y_cur      <= '0;
      z_cur      <= '0;
      x_tgt      <= '0;
      y_tgt      <= '0;
      z_tgt      <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      presc  <= tick ? '0 : presc + PRESCALE_W'(1);
`ifdef SPM_OFFSET_MOVER_ABORT_EN
      if (bus.abort && (state != ST_IDLE)) begin
        state <= ST_IDLE;
        x_tgt <= x_cur;
        y_tgt <= y_cur;
        z_tgt <= z_cur;
      end else
`endif
      // A start always wins, including over a settle expiry in the same cycle.
      if (bus.start) begin
        state <= ST_MOVE;
        presc <= '0;
        x_tgt <= bus.x_target;
        y_tgt <= bus.y_target;
        z_tgt <= bus.z_target;
      end else begin
        case (state)
          ST_MOVE: begin
            if (tick) begin
              x_cur <= x_nxt;
              y_cur <= y_nxt;
              z_cur <= z_nxt;
              if ((x_nxt == x_tgt) && (y_nxt == y_tgt) && (z_nxt == z_tgt)) begin
                state      <= ST_SETTLE;
                settle_cnt <= SETTLE_LOAD;
              end
            end
          end
          ST_SETTLE: begin
            if (settle_cnt == '0) begin
              state  <= ST_IDLE;
              done_q <= 1'b1;
            end else begin
              settle_cnt <= settle_cnt - SETTLE_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.x0   = x_cur;
  assign bus.y0   = y_cur;
  assign bus.z0   = z_cur;
  assign bus.busy = (state != ST_IDLE);
  assign bus.done = done_q;

endmodule

// File: tb/tb_axis_spm_offset_mover.sv
// Scoreboard bench for axis_spm_offset_mover: stimulus pushes expected output events,
// a monitor pops one per observed change of (x0,y0,z0) or done pulse.
module tb_axis_spm_offset_mover;

  localparam int SETTLE = 16;

  typedef struct {
    string              name;
    logic signed [31:0] x, y, z;
    logic               busy, done;
    int                 at;
  } exp_t;

  logic a_clk = 1'b0;
  logic a_rst = 1'b1;

  axis_spm_offset_mover_if #(.PRESCALE_W(16)) bus ();

  axis_spm_offset_mover #(.SETTLE_CYCLES(SETTLE), .PRESCALE_W(16)) dut (
    .a_clk (a_clk),
    .a_rst (a_rst),
    .bus   (bus)
  );

  always #5 a_clk = ~a_clk;

  exp_t exp_q[$];
  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int start_cyc   = 0;
  logic signed [31:0] px = '0, py = '0, pz = '0;

  always @(posedge a_clk) cyc <= cyc + 1;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    int gap;
    gap = cyc - start_cyc;
    vectors++;
    if (bus.x0 !== e.x || bus.y0 !== e.y || bus.z0 !== e.z ||
        bus.busy !== e.busy || bus.done !== e.done || gap != e.at) begin
      miscompares++;
      $display("[TB] FAIL %s: got x=%0d y=%0d z=%0d busy=%0b done=%0b at=%0d, expected x=%0d y=%0d z=%0d busy=%0b done=%0b at=%0d",
               e.name, bus.x0, bus.y0, bus.z0, bus.busy, bus.done, gap,
               e.x, e.y, e.z, e.busy, e.done, e.at);
    end
  endtask

  // Monitor: every change of the offsets or a done pulse consumes one expected event.
  always begin
    @(posedge a_clk);
    #1;
    if (a_rst) begin
      exp_q.delete();
    end else if (bus.x0 !== px || bus.y0 !== py || bus.z0 !== pz || bus.done) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_event: got x=%0d y=%0d z=%0d done=%0b, expected no change",
                 bus.x0, bus.y0, bus.z0, bus.done);
      end else begin
        checkOutput(exp_q.pop_front());
      end
    end
    px = bus.x0;
    py = bus.y0;
    pz = bus.z0;
  end

  function automatic void pushExp(input string n, input logic signed [31:0] x, input logic signed [31:0] y,
                                  input logic signed [31:0] z, input logic b, input logic d, input int at);
    exp_t e;
    e.name = n; e.x = x; e.y = y; e.z = z; e.busy = b; e.done = d; e.at = at;
    exp_q.push_back(e);
  endfunction

  // Called at a negedge; start is sampled on the following posedge.
  task automatic applyStimulus(input logic signed [31:0] xt, input logic signed [31:0] yt,
                               input logic signed [31:0] zt, input logic [31:0] st, input logic [15:0] rd);
    bus.x_target = xt;
    bus.y_target = yt;
    bus.z_target = zt;
    bus.step     = st;
    bus.rate_div = rd;
    bus.start    = 1'b1;
    start_cyc    = cyc + 1;
    @(negedge a_clk);
    bus.start    = 1'b0;
  endtask

  task automatic waitDrain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge a_clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s_timeout: got %0d events pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (20) @(negedge a_clk);
  endtask

  task automatic pulseReset(input string name);
    #2 a_rst = 1'b1;
    #1;
    checkValue({name, "_x0"},   bus.x0, 32'd0);
    checkValue({name, "_y0"},   bus.y0, 32'd0);
    checkValue({name, "_z0"},   bus.z0, 32'd0);
    checkValue({name, "_busy"}, {31'd0, bus.busy}, 32'd0);
    checkValue({name, "_done"}, {31'd0, bus.done}, 32'd0);
    @(negedge a_clk);
    a_rst = 1'b0;
    repeat (2) @(negedge a_clk);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.x_target = '0; bus.y_target = '0; bus.z_target = '0;
    bus.step = '0; bus.rate_div = '0;
`ifdef SPM_OFFSET_MOVER_ABORT_EN
    bus.abort = 1'b0;
`endif
    #1;
    checkValue("reset_x0",   bus.x0, 32'd0);
    checkValue("reset_busy", {31'd0, bus.busy}, 32'd0);
    checkValue("reset_done", {31'd0, bus.done}, 32'd0);
    repeat (2) @(negedge a_clk);
    a_rst = 1'b0;
    repeat (2) @(negedge a_clk);

    // Prescaled ramp: rate_div=3 -> one step every 4th cycle.
    applyStimulus(5, 0, 0, 1, 3);
    for (int k = 1; k <= 5; k++) pushExp("prescale_step", k, 0, 0, 1'b1, 1'b0, 4 * k);
    pushExp("prescale_done", 5, 0, 0, 1'b0, 1'b1, 20 + SETTLE);
    waitDrain("prescale", 200);

    // Async reset in the middle of a move: zeros at once, no done afterwards.
    applyStimulus(-1000, 0, 0, 7, 0);
    for (int k = 1; k <= 4; k++) pushExp("abortmove_step", 5 - 7 * k, 0, 0, 1'b1, 1'b0, k);
    repeat (4) @(negedge a_clk);
    pulseReset("midmove_reset");
    repeat (20) @(negedge a_clk);

    // Main ramp on three axes with different distances.
    applyStimulus(1000, -250, 0, 100, 0);
    for (int k = 1; k <= 10; k++)
      pushExp("ramp_step", 100 * k, (k >= 3) ? -250 : -100 * k, 0, 1'b1, 1'b0, k);
    pushExp("ramp_done", 1000, -250, 0, 1'b0, 1'b1, 10 + SETTLE);
    waitDrain("ramp", 100);

    // Retarget mid-move from 500 back down to 0; only one done at the end.
    pulseReset("idle_reset");
    applyStimulus(1000, 0, 0, 10, 0);
    for (int k = 1; k <= 50; k++) pushExp("retarget_up", 10 * k, 0, 0, 1'b1, 1'b0, k);
    for (int i = 0; i < 200 && bus.x0 != 500; i++) @(negedge a_clk);
    checkValue("retarget_reach500", bus.x0, 32'd500);
    applyStimulus(0, 0, 0, 10, 0);
    for (int k = 1; k <= 50; k++) pushExp("retarget_down", 500 - 10 * k, 0, 0, 1'b1, 1'b0, k);
    pushExp("retarget_done", 0, 0, 0, 1'b0, 1'b1, 50 + SETTLE);
    waitDrain("retarget", 200);

    // Full-scale steps toward both ends of the signed range.
    applyStimulus(32'h7FFF_FFF0, 32'h8000_0000, 0, 32'h7FFF_FFFF, 0);
    pushExp("extreme_t1", 32'h7FFF_FFF0, 32'h8000_0001, 0, 1'b1, 1'b0, 1);
    pushExp("extreme_t2", 32'h7FFF_FFF0, 32'h8000_0000, 0, 1'b1, 1'b0, 2);
    pushExp("extreme_done", 32'h7FFF_FFF0, 32'h8000_0000, 0, 1'b0, 1'b1, 2 + SETTLE);
    waitDrain("extreme", 100);
    applyStimulus(32'h8000_0000, 32'h8000_0000, 0, 32'h7FFF_FFFF, 0);
    pushExp("swing_t1", -15, 32'h8000_0000, 0, 1'b1, 1'b0, 1);
    pushExp("swing_t2", 32'h8000_0000, 32'h8000_0000, 0, 1'b1, 1'b0, 2);
    pushExp("swing_done", 32'h8000_0000, 32'h8000_0000, 0, 1'b0, 1'b1, 2 + SETTLE);
    waitDrain("swing", 100);

    // step=0 behaves as step=1.
    applyStimulus(32'h8000_0000, 32'h8000_0000, 3, 0, 0);
    for (int k = 1; k <= 3; k++) pushExp("step0", 32'h8000_0000, 32'h8000_0000, k, 1'b1, 1'b0, k);
    pushExp("step0_done", 32'h8000_0000, 32'h8000_0000, 3, 1'b0, 1'b1, 3 + SETTLE);
    waitDrain("step0", 100);

    // step bit 31 is ignored: effective step is 2.
    applyStimulus(32'h8000_0000, 32'h8000_0000, -1, 32'h8000_0002, 0);
    pushExp("stepmsb_t1", 32'h8000_0000, 32'h8000_0000, 1, 1'b1, 1'b0, 1);
    pushExp("stepmsb_t2", 32'h8000_0000, 32'h8000_0000, -1, 1'b1, 1'b0, 2);
    pushExp("stepmsb_done", 32'h8000_0000, 32'h8000_0000, -1, 1'b0, 1'b1, 2 + SETTLE);
    waitDrain("stepmsb", 100);

    // Already at target: arrival on the first tick (rate_div=2), only done is seen.
    applyStimulus(32'h8000_0000, 32'h8000_0000, -1, 5, 2);
    pushExp("noop_done", 32'h8000_0000, 32'h8000_0000, -1, 1'b0, 1'b1, 3 + SETTLE);
    waitDrain("noop", 100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no completion, expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
